fpu_exception_resolver: RTL and testbench

- Sequencing stage directly downstream of EXCEPTION_MODULE in the 8-bit FPU (1 sign, 4 exponent, 3 mantissa bits).
- Latches one request: opcode, operands, OP_IS_EXCEPTION and FP_EXCE.
- Exceptional requests are resolved locally to an IEEE-style special result. All others are dispatched to the arithmetic core, whose result is awaited.
- Presents the final result over a valid/ready handshake and keeps sticky exception flags.

---
 rtl/fpu_exception_resolver.sv | 232 +++++++++++++++++++++++
 tb/tb_fpu_exception_resolver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_exception_resolver.sv
// ---------------------------------------------------------------------------
// fpu_exception_resolver
//
// This stage sits directly after EXCEPTION_MODULE in the 8-bit FPU. The FP8
// format is 1 sign bit, 4 exponent bits and 3 mantissa bits.
//
// It accepts one request at a time. An exceptional request is turned into an
// IEEE-style special result inside this block. Any other request goes to the
// arithmetic core, and the block waits for the core result. The final result
// leaves over a valid/ready handshake. Exception flags are sticky.
//
// Optional feature: define FPU_EXC_TIMEOUT_EN to enable a watchdog on the core.
// If the core does not answer within TIMEOUT_CYCLES cycles of WAIT_CORE, the
// request is forced to complete as a quiet NaN tagged sNaN, and the timeout
// flag is set. Without the macro there is no counter and bit 4 stays 0.
//
// Ports
//   CLK, RST_N          clock, async active-low reset
//   IN_VALID/IN_READY   request handshake
//   FP_OPERATION        opcode (add/sub/mul/div)
//   OP_A, OP_B          operands
//   OP_IS_EXCEPTION     upstream detected an exception
//   FP_EXCE             upstream exception code
//   CORE_START          one-cycle launch pulse to the arithmetic core
//   CORE_OP/A/B         registered request fields forwarded to the core
//   CORE_DONE           core result valid (single-cycle pulse)
//   CORE_RESULT         core result
//   OUT_VALID/OUT_READY result handshake
//   RESULT, RESULT_EXCE final result and its exception tag
//   STICKY_FLAGS        {timeout, zero_div, invalid_inf, snan, qnan}
//   FLAGS_CLR           synchronous clear; a simultaneous set wins
//
// Exception codes mirror FPU_PACK.v:
//   NO=0, qNAN=1, sNAN=2, INF=3, ZERO_DIV=4
//
// State | meaning
// ------+-----------------------------------------------
// IDLE  | ready for a request
// RESOLVE | build the special result from the latched code
// WAIT_CORE | core launched, waiting for CORE_DONE
// OUTPUT | result presented until OUT_READY
// ---------------------------------------------------------------------------
module fpu_exception_resolver #(
  parameter logic [7:0] QNAN_VAL       = 8'h7C,
  parameter logic [6:0] INF_MAG        = 7'h78,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [1:0] FP_OPERATION,
  input  logic [7:0] OP_A,
  input  logic [7:0] OP_B,
  input  logic       OP_IS_EXCEPTION,
  input  logic [2:0] FP_EXCE,
  output logic       CORE_START,
  output logic [1:0] CORE_OP,
  output logic [7:0] CORE_A,
  output logic [7:0] CORE_B,
  input  logic       CORE_DONE,
  input  logic [7:0] CORE_RESULT,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] RESULT,
  output logic [2:0] RESULT_EXCE,
  output logic [4:0] STICKY_FLAGS,
  input  logic       FLAGS_CLR
);

  localparam logic [2:0] EXC_NO    = 3'd0;
  localparam logic [2:0] EXC_QNAN  = 3'd1;
  localparam logic [2:0] EXC_SNAN  = 3'd2;
  localparam logic [2:0] EXC_INF   = 3'd3;
  localparam logic [2:0] EXC_ZDIV  = 3'd4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RESOLVE = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_OUTPUT  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [2:0] code_q, code_d;
  logic [7:0] result_q, result_d;
  logic [2:0] rexce_q, rexce_d;
  logic       start_q, start_d;
  logic [4:0] flags_q, flags_d, flags_set;

  logic       a_nan, a_zero;
  logic [7:0] res_special;
  logic [2:0] code_special;
  logic [4:0] flag_special;

`ifdef FPU_EXC_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] WD_LOAD = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wd_q, wd_d;

  // Down-counter: loaded while idle, so it is fresh on entry to WAIT_CORE.
  // It reaches zero in the last allowed WAIT_CORE cycle.
  always_comb begin
    wd_d = wd_q;
    if (state_q == S_IDLE) wd_d = WD_LOAD;
    else if (state_q == S_WAIT && wd_q != '0) wd_d = wd_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) wd_q <= WD_LOAD;
    else        wd_q <= wd_d;
  end
`endif

  assign a_nan  = (&a_q[6:3]) && (|a_q[2:0]);
  assign a_zero = ~|a_q[6:0];

  // Special result for the latched code. Any code not listed here
  // (including NO_EXCE with OP_IS_EXCEPTION set) is treated as sNaN.
  always_comb begin
    res_special  = QNAN_VAL;
    code_special = EXC_SNAN;
    flag_special = 5'b00010;
    case (code_q)
      EXC_QNAN: begin
        res_special  = a_nan ? a_q : b_q;
        code_special = EXC_QNAN;
        flag_special = 5'b00001;
      end
      EXC_INF: begin
        res_special  = QNAN_VAL;
        code_special = EXC_INF;
        flag_special = 5'b00100;
      end
      EXC_ZDIV: begin
        res_special  = a_zero ? QNAN_VAL : {a_q[7] ^ b_q[7], INF_MAG};
        code_special = EXC_ZDIV;
        flag_special = 5'b01000;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    code_d    = code_q;
    result_d  = result_q;
    rexce_d   = rexce_q;
    start_d   = 1'b0;
    flags_set = '0;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          op_d   = FP_OPERATION;
          a_d    = OP_A;
          b_d    = OP_B;
          code_d = FP_EXCE;
          if (OP_IS_EXCEPTION) begin
            state_d = S_RESOLVE;
          end else begin
            start_d = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_RESOLVE: begin
        result_d  = res_special;
        rexce_d   = code_special;
        flags_set = flag_special;
        state_d   = S_OUTPUT;
      end
      S_WAIT: begin
        if (CORE_DONE) begin
          result_d = CORE_RESULT;
          rexce_d  = EXC_NO;
          state_d  = S_OUTPUT;
        end
`ifdef FPU_EXC_TIMEOUT_EN
        else if (wd_q == '0) begin
          result_d     = QNAN_VAL;
          rexce_d      = EXC_SNAN;
          flags_set[4] = 1'b1;
          state_d      = S_OUTPUT;
        end
`endif
      end
      default: begin
        if (OUT_READY) state_d = S_IDLE;
      end
    endcase
    // A set in the same cycle as a clear takes priority.
    flags_d = (FLAGS_CLR ? 5'b00000 : flags_q) | flags_set;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      code_q   <= EXC_NO;
      result_q <= '0;
      rexce_q  <= EXC_NO;
      start_q  <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      code_q   <= code_d;
      result_q <= result_d;
      rexce_q  <= rexce_d;
      start_q  <= start_d;
      flags_q  <= flags_d;
    end
  end

  assign IN_READY     = (state_q == S_IDLE);
  assign OUT_VALID    = (state_q == S_OUTPUT);
  assign CORE_START   = start_q;
  assign CORE_OP      = op_q;
  assign CORE_A       = a_q;
  assign CORE_B       = b_q;
  assign RESULT       = result_q;
  assign RESULT_EXCE  = rexce_q;
  assign STICKY_FLAGS = flags_q;

endmodule

// File: tb/tb_fpu_exception_resolver.sv
module tb_fpu_exception_resolver;

  localparam logic [2:0] EXC_NO   = 3'd0;
  localparam logic [2:0] EXC_QNAN = 3'd1;
  localparam logic [2:0] EXC_SNAN = 3'd2;
  localparam logic [2:0] EXC_INF  = 3'd3;
  localparam logic [2:0] EXC_ZDIV = 3'd4;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [1:0] FP_OPERATION = '0;
  logic [7:0] OP_A = '0, OP_B = '0;
  logic       OP_IS_EXCEPTION = 1'b0;
  logic [2:0] FP_EXCE = '0;
  logic       CORE_START;
  logic [1:0] CORE_OP;
  logic [7:0] CORE_A, CORE_B;
  logic       CORE_DONE = 1'b0;
  logic [7:0] CORE_RESULT = '0;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [7:0] RESULT;
  logic [2:0] RESULT_EXCE;
  logic [4:0] STICKY_FLAGS;
  logic       FLAGS_CLR = 1'b0;

  fpu_exception_resolver dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .FP_OPERATION(FP_OPERATION), .OP_A(OP_A), .OP_B(OP_B),
    .OP_IS_EXCEPTION(OP_IS_EXCEPTION), .FP_EXCE(FP_EXCE),
    .CORE_START(CORE_START), .CORE_OP(CORE_OP), .CORE_A(CORE_A), .CORE_B(CORE_B),
    .CORE_DONE(CORE_DONE), .CORE_RESULT(CORE_RESULT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RESULT(RESULT), .RESULT_EXCE(RESULT_EXCE),
    .STICKY_FLAGS(STICKY_FLAGS), .FLAGS_CLR(FLAGS_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] res;
    logic [2:0] exce;
    logic [4:0] flags;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [4:0] mflags = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference resolution of an exceptional request, built from the FP8 format.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] code);
    exp_t e;
    logic a_is_nan, a_is_zero;
    a_is_nan  = (a[6:3] == 4'hF) && (a[2:0] != 3'b000);
    a_is_zero = (a[6:0] == 7'h00);
    e.flags = '0;
    case (code)
      EXC_QNAN: begin e.res = a_is_nan ? a : b; e.exce = EXC_QNAN; end
      EXC_INF:  begin e.res = 8'h7C; e.exce = EXC_INF; end
      EXC_ZDIV: begin
        e.exce = EXC_ZDIV;
        if (a_is_zero) e.res = 8'h7C;
        else           e.res = (a[7] != b[7]) ? 8'hF8 : 8'h78;
      end
      default:  begin e.res = 8'h7C; e.exce = EXC_SNAN; end
    endcase
    return e;
  endfunction

  function automatic logic [4:0] flag_of(input logic [2:0] exce);
    case (exce)
      EXC_QNAN: return 5'b00001;
      EXC_SNAN: return 5'b00010;
      EXC_INF:  return 5'b00100;
      EXC_ZDIV: return 5'b01000;
      default:  return 5'b00000;
    endcase
  endfunction

  // Present one request and return one cycle after it is accepted.
  task automatic drive_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic isexc, input logic [2:0] code);
    int n = 0;
    while (!IN_READY && n < 20) begin tick(); n++; end
    if (!IN_READY) chk("in_ready_wait", 0, 1);
    FP_OPERATION = op; OP_A = a; OP_B = b; OP_IS_EXCEPTION = isexc; FP_EXCE = code;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
  endtask

  // Wait for a result, compare it with the scoreboard head, optionally stall
  // for `hold` cycles, and then complete the handshake.
  task automatic collect(input int hold);
    exp_t e;
    int n = 0;
    while (!OUT_VALID && n < 40) begin tick(); n++; end
    if (!OUT_VALID) chk("out_valid_wait", 0, 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("result", RESULT, e.res);
    chk("result_exce", RESULT_EXCE, e.exce);
    chk("sticky", STICKY_FLAGS, e.flags);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", OUT_VALID, 1);
      chk("hold_result", RESULT, e.res);
    end
    chk("in_ready_in_out", IN_READY, 0);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk("out_valid_after_hs", OUT_VALID, 0);
    chk("in_ready_after_hs", IN_READY, 1);
  endtask

  task automatic exc_case(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] code, input int hold);
    exp_t e;
    e = model(a, b, code);
    mflags = mflags | flag_of(e.exce);
    e.flags = mflags;
    sb.push_back(e);
    drive_req(op, a, b, 1'b1, code);
    chk("exc_n1_valid", OUT_VALID, 0);
    chk("exc_no_start", CORE_START, 0);
    tick();
    chk("exc_n2_valid", OUT_VALID, 1);
    chk("exc_no_start2", CORE_START, 0);
    collect(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    exp_t e;
    tick(); tick();
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_core_start", CORE_START, 0);
    chk("rst_result", RESULT, 8'h00);
    chk("rst_result_exce", RESULT_EXCE, EXC_NO);
    chk("rst_sticky", STICKY_FLAGS, 0);
    chk("rst_core_ab", {CORE_OP, CORE_A, CORE_B}, 0);
    RST_N = 1'b1;
    tick();

    // Reset during WAIT_CORE, then a late CORE_DONE from the aborted op.
    drive_req(OP_ADD, 8'h11, 8'h22, 1'b0, EXC_NO);
    tick(); tick();
    chk("wait_in_ready", IN_READY, 0);
    RST_N = 1'b0;
    #2;
    chk("arst_in_ready", IN_READY, 1);
    chk("arst_core_a", CORE_A, 0);
    RST_N = 1'b1;
    tick();
    CORE_DONE = 1'b1; CORE_RESULT = 8'h55;
    tick();
    CORE_DONE = 1'b0;
    chk("late_done_valid", OUT_VALID, 0);
    chk("late_done_ready", IN_READY, 1);
    chk("late_done_result", RESULT, 0);
    tick();
    chk("late_done_valid2", OUT_VALID, 0);

    // Exception path. -0 as the divisor gives a negative infinity.
    exc_case(OP_DIV, 8'h38, 8'h80, EXC_ZDIV, 0);
    exc_case(OP_ADD, 8'h78, 8'hF8, EXC_INF, 5);

    // Core path.
    e.res = 8'h48; e.exce = EXC_NO; e.flags = mflags;
    sb.push_back(e);
    drive_req(OP_MUL, 8'h30, 8'h40, 1'b0, EXC_NO);
    chk("core_start", CORE_START, 1);
    chk("core_a", CORE_A, 8'h30);
    chk("core_b", CORE_B, 8'h40);
    chk("core_op", CORE_OP, OP_MUL);
    tick();
    chk("core_start_pulse", CORE_START, 0);
    tick();
    tick();
    chk("core_wait_valid", OUT_VALID, 0);
    CORE_DONE = 1'b1; CORE_RESULT = 8'h48;
    tick();
    CORE_DONE = 1'b0;
    chk("core_out_valid", OUT_VALID, 1);
    collect(0);

    // NaN selection, an unknown code and 0/0.
    exc_case(OP_ADD, 8'h7D, 8'h10, EXC_QNAN, 0);
    exc_case(OP_SUB, 8'h10, 8'hFA, EXC_QNAN, 0);
    exc_case(OP_MUL, 8'h20, 8'h21, 3'd5, 0);
    exc_case(OP_DIV, 8'h80, 8'h00, EXC_ZDIV, 1);

    // sNaN flag set in the same cycle as FLAGS_CLR: the set wins.
    e.res = 8'h7C; e.exce = EXC_SNAN; e.flags = 5'b00010;
    sb.push_back(e);
    mflags = 5'b00010;
    drive_req(OP_SUB, 8'h79, 8'h10, 1'b1, EXC_SNAN);
    FLAGS_CLR = 1'b1;
    tick();
    FLAGS_CLR = 1'b0;
    chk("snan_valid", OUT_VALID, 1);
    collect(0);
    FLAGS_CLR = 1'b1;
    tick();
    FLAGS_CLR = 1'b0;
    mflags = '0;
    chk("flags_cleared", STICKY_FLAGS, 0);

`ifdef FPU_EXC_TIMEOUT_EN
    e.res = 8'h7C; e.exce = EXC_SNAN; e.flags = mflags | 5'b10000;
    sb.push_back(e);
    drive_req(OP_ADD, 8'h01, 8'h02, 1'b0, EXC_NO);
    for (int i = 0; i < 15; i++) tick();
    chk("wd_16th_cycle_valid", OUT_VALID, 0);
    tick();
    chk("wd_expired_valid", OUT_VALID, 1);
    collect(0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
